// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch time base: state encoding,
// default frequency parameters and a constant-safe clog2 helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam int DEF_BOARD_HZ    = 100_000_000;
    localparam int DEF_TICK_HZ     = 100;
    localparam int DEF_SLOW_DIVIDE = 100;

    // Smallest r with 2**r >= value; 0 for value <= 1.
    function automatic int clog2(input longint value);
        int result;
        result = 0;
        for (int i = 0; i < 62; i++) begin
            if ((longint'(1) << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stopwatch_timebase_if.sv
// Command/strobe bundle between the stopwatch controls and the time base.
// The master side issues start/stop/clear pulses and observes the state
// flags and strobes; the slave side is the time base itself.
interface stopwatch_timebase_if;
    logic start;
    logic stop;
    logic clear;
    logic running;
    logic paused;
    logic tick;
    logic tick_slow;

    modport master (
        output start, stop, clear,
        input  running, paused, tick, tick_slow
    );

    modport slave (
        input  start, stop, clear,
        output running, paused, tick, tick_slow
    );
endinterface

// File: rtl/timebase_prescaler.sv
// Fast-tick generator. Default build: integer divider counting 0..DIV-1.
// With TIMEBASE_PHASE_ACC_EN defined: phase accumulator that adds TICK per
// enabled cycle and wraps at BOARD, giving an exact long-run rate.
// The tick output is combinational (terminal count this cycle); the caller
// registers it. clr has priority over en and suppresses the tick.
module timebase_prescaler
    import stopwatch_pkg::*;
#(
    parameter int BOARD_HZ = DEF_BOARD_HZ,
    parameter int TICK_HZ  = DEF_TICK_HZ
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

`ifdef TIMEBASE_PHASE_ACC_EN
    localparam int AW = clog2(BOARD_HZ) + 1;
    localparam logic [AW:0] INC = (AW+1)'(TICK_HZ);
    localparam logic [AW:0] BRD = (AW+1)'(BOARD_HZ);

    logic [AW-1:0] r_acc;
    logic [AW:0]   w_sum;
    logic          w_wrap;

    assign w_sum  = {1'b0, r_acc} + INC;
    assign w_wrap = (w_sum >= BRD);

    // Accumulate phase while enabled; subtract one period on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_acc <= '0;
        else if (clr)  r_acc <= '0;
        else if (en)   r_acc <= w_wrap ? AW'(w_sum - BRD) : w_sum[AW-1:0];
    end

    assign tick = en & ~clr & w_wrap;
`else
    localparam int DIV = BOARD_HZ / TICK_HZ;
    localparam int PW  = clog2(DIV);
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);

    logic [PW-1:0] r_cnt;
    logic          w_term;

    assign w_term = (r_cnt == TERM);

    // Count enabled cycles 0..DIV-1, never passing the terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_cnt <= '0;
        else if (clr)  r_cnt <= '0;
        else if (en)   r_cnt <= w_term ? '0 : r_cnt + PW'(1);
    end

    assign tick = en & ~clr & w_term;
`endif

endmodule

// File: rtl/stopwatch_timebase.sv
// Run-controlled stopwatch time base: IDLE/RUN/PAUSE control, fast tick
// from timebase_prescaler and a slow tick every SLOW_DIVIDE fast ticks.
// Optional build macro (in the prescaler): TIMEBASE_PHASE_ACC_EN.
module stopwatch_timebase
    import stopwatch_pkg::*;
#(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = DEF_BOARD_HZ,
    parameter int TICK_FREQUENCY_IN_HZ        = DEF_TICK_HZ,
    parameter int SLOW_DIVIDE                 = DEF_SLOW_DIVIDE
) (
    input  logic               clk,
    input  logic               rst,
    stopwatch_timebase_if.slave bus
);

    generate
        if (BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_FREQUENCY_IN_HZ < 2) begin : g_bad_div
            $error("stopwatch_timebase: BOARD/TICK must be at least 2");
        end
        if (SLOW_DIVIDE < 1) begin : g_bad_slow
            $error("stopwatch_timebase: SLOW_DIVIDE must be at least 1");
        end
    endgenerate

    localparam int SW_RAW = clog2(SLOW_DIVIDE);
    localparam int SW     = (SW_RAW < 1) ? 1 : SW_RAW;
    localparam logic [SW-1:0] SLOW_TERM = SW'(SLOW_DIVIDE - 1);

    state_e        r_state;
    state_e        w_state_nxt;
    logic          w_running;
    logic          w_paused;
    logic          w_pre_tick;
    logic [SW-1:0] r_slow;
    logic          r_tick;
    logic          r_tick_slow;

    // State register; reset parks the stopwatch in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state with clear > stop > start; stop wins over start, and a
    // stop outside RUN leaves the state alone.
    always_comb begin
        w_state_nxt = r_state;
        w_running   = (r_state == ST_RUN);
        w_paused    = (r_state == ST_PAUSE);
        if (bus.clear)
            w_state_nxt = ST_IDLE;
        else if (bus.stop) begin
            if (r_state == ST_RUN) w_state_nxt = ST_PAUSE;
        end
        else if (bus.start)
            w_state_nxt = ST_RUN;
    end

    timebase_prescaler #(
        .BOARD_HZ (BOARD_CLOCK_FREQUENCY_IN_HZ),
        .TICK_HZ  (TICK_FREQUENCY_IN_HZ)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (r_state == ST_RUN),
        .clr  (bus.clear),
        .tick (w_pre_tick)
    );

    // Slow counter of fast ticks plus the registered strobes. A terminal
    // count in the last RUN cycle still strobes in the first PAUSE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slow      <= '0;
            r_tick      <= 1'b0;
            r_tick_slow <= 1'b0;
        end else begin
            r_tick      <= w_pre_tick;
            r_tick_slow <= w_pre_tick & (r_slow == SLOW_TERM);
            if (bus.clear)
                r_slow <= '0;
            else if (w_pre_tick)
                r_slow <= (r_slow == SLOW_TERM) ? '0 : r_slow + SW'(1);
        end
    end

    assign bus.running   = w_running;
    assign bus.paused    = w_paused;
    assign bus.tick      = r_tick;
    assign bus.tick_slow = r_tick_slow;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Scoreboard bench: several time-base instances share one command stream;
// a reference model built from elapsed RUN cycles predicts every cycle's
// outputs, and a negedge monitor pops and compares them.
module tb_stopwatch_timebase;

    localparam int NI = 4;
    localparam int BRD [NI] = '{1000, 1000, 200, 1000};
    localparam int TCK [NI] = '{ 100,  100, 100,  300};
    localparam int SLW [NI] = '{   4,    1,   2,    3};

    typedef struct packed {
        logic          run;
        logic          pau;
        logic [NI-1:0] tk;
        logic [NI-1:0] sl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [NI-1:0] act_run, act_pau, act_tick, act_slow;

    int n_chk  = 0;
    int n_fail = 0;
    exp_t q[$];

    // model state: 0 idle, 1 run, 2 pause; m_n = RUN cycles since clear
    int            m_st = 0;
    longint        m_n  = 0;
    logic [NI-1:0] m_tick = '0;
    logic [NI-1:0] m_slow = '0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        stopwatch_timebase_if ifc();
        assign ifc.start   = start;
        assign ifc.stop    = stop;
        assign ifc.clear   = clear;
        assign act_run[g]  = ifc.running;
        assign act_pau[g]  = ifc.paused;
        assign act_tick[g] = ifc.tick;
        assign act_slow[g] = ifc.tick_slow;
        stopwatch_timebase #(
            .BOARD_CLOCK_FREQUENCY_IN_HZ (BRD[g]),
            .TICK_FREQUENCY_IN_HZ        (TCK[g]),
            .SLOW_DIVIDE                 (SLW[g])
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc.slave)
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Ticks completed after n RUN cycles.
    function automatic longint kcount(input int i, input longint n);
`ifdef TIMEBASE_PHASE_ACC_EN
        return (n * TCK[i]) / BRD[i];
`else
        return n / (BRD[i] / TCK[i]);
`endif
    endfunction

    // One cycle: record expectation for this cycle, drive commands, advance model.
    task automatic cyc(input logic st, input logic sp, input logic cl);
        exp_t e;
        longint k0, k1;
        @(posedge clk); #1;
        e.run = (m_st == 1);
        e.pau = (m_st == 2);
        e.tk  = m_tick;
        e.sl  = m_slow;
        q.push_back(e);
        start = st; stop = sp; clear = cl;
        for (int i = 0; i < NI; i++) begin
            m_tick[i] = 1'b0;
            m_slow[i] = 1'b0;
            if (m_st == 1 && !cl) begin
                k0 = kcount(i, m_n);
                k1 = kcount(i, m_n + 1);
                m_tick[i] = (k1 > k0);
                m_slow[i] = (k1 > k0) && (k1 % SLW[i] == 0);
            end
        end
        if (cl)             m_n = 0;
        else if (m_st == 1) m_n = m_n + 1;
        if (cl)             m_st = 0;
        else if (sp)        m_st = (m_st == 1) ? 2 : m_st;
        else if (st)        m_st = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset between edges while running.
    task automatic mid_reset();
        #5;
        check("pre_rst_running", 64'(act_run), 64'({NI{1'b1}}));
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        #1;
        check("async_rst_outputs", 64'({act_run, act_pau, act_tick, act_slow}), 64'(0));
        m_st = 0; m_n = 0; m_tick = '0; m_slow = '0;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    // Monitor: compare whatever expectation was queued for this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("state", 64'({act_run, act_pau}), 64'({{NI{e.run}}, {NI{e.pau}}}));
            check("ticks", 64'({act_tick, act_slow}), 64'({e.tk, e.sl}));
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #3;
        check("reset_values", 64'({act_run, act_pau, act_tick, act_slow}), 64'(0));
        #1 rst = 1'b0;

        // cadence: start at cycle 5, stop 3 cycles after the tick at 46
        idle(5);
        cyc(1'b1, 1'b0, 1'b0);
        idle(43);
        cyc(1'b0, 1'b1, 1'b0);
        idle(19);
        cyc(1'b1, 1'b0, 1'b0);
        idle(15);

        // priority: all three in RUN, then start+stop in PAUSE
        cyc(1'b1, 1'b1, 1'b1);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0);
        idle(12);
        cyc(1'b0, 1'b1, 1'b0);
        idle(3);
        cyc(1'b1, 1'b1, 1'b0);
        idle(5);
        cyc(1'b1, 1'b0, 1'b0);
        idle(20);

        // clear on a terminal-count cycle, then stop on one
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        idle(9);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        idle(9);
        cyc(1'b0, 1'b1, 1'b0);
        idle(5);
        cyc(1'b0, 1'b0, 1'b1);

        // reset mid-run; nothing may tick until a new start
        cyc(1'b1, 1'b0, 1'b0);
        idle(13);
        mid_reset();
        idle(30);
        cyc(1'b1, 1'b0, 1'b0);
        idle(25);

        // random command stream
        repeat (2500) begin
            cyc($urandom_range(0, 19) == 0,
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 99) == 0);
        end
        idle(2);
        @(posedge clk);
        @(negedge clk); #1;
        check("scoreboard_drained", 64'(q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
